// File: rtl/bop_interval_table.sv
// Circular store of closed address intervals fed by the BOP interval detector.
// Answers per-cycle containment lookups, merges touching intervals, and supports invalidate/flush.
module bop_interval_table #(
    parameter int DEPTH = 8,
    parameter int AW    = 32,
    parameter int CNT_W = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       wr_en_i,
    input  logic [AW-1:0]              wr_first_i,
    input  logic [AW-1:0]              wr_last_i,
    input  logic                       inv_en_i,
    input  logic [AW-1:0]              inv_addr_i,
    input  logic [AW-1:0]              lookup_addr_i,
    output logic                       hit_o,
    output logic                       hit_first_o,
    output logic [$clog2(DEPTH)-1:0]   hit_idx_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic [CNT_W-1:0]           evict_cnt_o
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [AW:0] ONE_EXT = (AW+1)'(1);

    // Strobe semantics: wr_en_i/inv_en_i/flush_i are single-cycle pulses that are
    // always accepted on the clock edge; there is no ready signal and no stall.
    logic              valid_q [DEPTH];
    logic [AW-1:0]     first_q [DEPTH];
    logic [AW-1:0]     last_q  [DEPTH];
    logic [IW-1:0]     wr_ptr_q;
    logic [CNT_W-1:0]  evict_q;

    logic [DEPTH-1:0]  inv_hit;
    logic [DEPTH-1:0]  cand;
    logic              merge_any;
    logic [IW-1:0]     merge_idx;
    logic [AW-1:0]     merged_first;
    logic [AW-1:0]     merged_last;
    logic              wr_ok;

    always_comb begin
        hit_o     = 1'b0;
        hit_idx_o = '0;
        // Scan downwards so the lowest matching index is the one that sticks.
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (valid_q[i] && first_q[i] <= lookup_addr_i && lookup_addr_i <= last_q[i]) begin
                hit_o     = 1'b1;
                hit_idx_o = IW'(i);
            end
        end
        hit_first_o = hit_o && (lookup_addr_i == first_q[hit_idx_o]);
    end

    always_comb begin
        count_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_o = count_o + CW'(valid_q[i]);
        end
        full_o = (count_o == CW'(DEPTH));
    end

    assign evict_cnt_o = evict_q;
    assign wr_ok       = wr_en_i && (wr_first_i <= wr_last_i);

    // The +1 comparisons run one bit wider so an interval ending at all-ones never wraps.
    always_comb begin
        merge_any = 1'b0;
        merge_idx = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            inv_hit[i] = inv_en_i && valid_q[i] &&
                         first_q[i] <= inv_addr_i && inv_addr_i <= last_q[i];
            cand[i]    = valid_q[i] && !inv_hit[i] &&
                         ({1'b0, wr_first_i} <= {1'b0, last_q[i]} + ONE_EXT) &&
                         ({1'b0, first_q[i]} <= {1'b0, wr_last_i} + ONE_EXT);
            if (cand[i]) begin
                merge_any = 1'b1;
                merge_idx = IW'(i);
            end
        end
        merged_first = (wr_first_i < first_q[merge_idx]) ? wr_first_i : first_q[merge_idx];
        merged_last  = (wr_last_i  > last_q[merge_idx])  ? wr_last_i  : last_q[merge_idx];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                first_q[i] <= '0;
                last_q[i]  <= '0;
            end
            wr_ptr_q <= '0;
            evict_q  <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
            end
            wr_ptr_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (inv_hit[i]) begin
                    valid_q[i] <= 1'b0;
                end
            end
            if (wr_ok) begin
                if (merge_any) begin
                    first_q[merge_idx] <= merged_first;
                    last_q[merge_idx]  <= merged_last;
                end else begin
                    // Later assignment wins over a same-cycle invalidate of this slot.
                    valid_q[wr_ptr_q] <= 1'b1;
                    first_q[wr_ptr_q] <= wr_first_i;
                    last_q[wr_ptr_q]  <= wr_last_i;
                    wr_ptr_q          <= wr_ptr_q + IW'(1);
                    if (valid_q[wr_ptr_q] && !inv_hit[wr_ptr_q] && evict_q != '1) begin
                        evict_q <= evict_q + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule
